// File: rtl/vlsu_seq_pkg.sv
// Shared definitions for the vector load/store sequencer: lane count default,
// FSM state encoding, opcode values and the element alignment helper.
package vlsu_seq_pkg;

    localparam int NLANE_DEF = 4;

    localparam logic OP_VLW = 1'b0;
    localparam logic OP_VSW = 1'b1;

    localparam logic [31:0] STRIDE_FIXED = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } vlsu_state_e;

    function automatic logic word_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/vlsu_seq_mem_arb2.sv
// Two-way round-robin grant between the scalar LSU and the vector sequencer.
// Grant is combinational; the preference pointer only moves on an accepted request.
module mem_arb2 (
    input  logic clk,
    input  logic rstn,
    input  logic req_s_i,
    input  logic req_v_i,
    input  logic accept_i,
    output logic grant_s_o,
    output logic grant_v_o
);

    logic prefer_s_q, prefer_s_d;

    always_comb begin
        grant_s_o  = req_s_i & (~req_v_i | prefer_s_q);
        grant_v_o  = req_v_i & ~grant_s_o;
        prefer_s_d = prefer_s_q;
        // Whoever just won yields priority to the other side next time.
        if (accept_i) begin
            prefer_s_d = grant_v_o;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prefer_s_q <= 1'b1;
        end else begin
            prefer_s_q <= prefer_s_d;
        end
    end

endmodule

// File: rtl/vlsu_seq.sv
// Vector load/store sequencer sharing one memory port with the scalar LSU.
// Define VLSU_STRIDE_EN to add a per-issue element stride (default fixed stride 4).
//
//   state   | meaning
//   IDLE    | issue_ready high, waiting for a vector op
//   REQ     | requesting element k (or flagging misalignment)
//   WAIT    | vector load element k outstanding
//   DONE    | one-cycle done pulse, err valid
module vlsu_seq
    import vlsu_seq_pkg::*;
#(
    parameter int NLANE = NLANE_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  issue_store,
    input  logic [31:0]           issue_base,
    input  logic [31:0]           issue_imm,
`ifdef VLSU_STRIDE_EN
    input  logic [31:0]           issue_stride,
`endif
    input  logic [32*NLANE-1:0]   issue_wdata,
    output logic                  done,
    output logic                  err,
    output logic [32*NLANE-1:0]   rdata,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  logic                  s_we,
    input  logic [31:0]           s_addr,
    input  logic [31:0]           s_wdata,
    output logic                  s_rvalid,
    output logic [31:0]           s_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int KW = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NLANE - 1);

    vlsu_state_e         state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                op_q, op_d;
    logic [31:0]         addr_q, addr_d;
    logic [32*NLANE-1:0] wdata_q, wdata_d;
    logic [32*NLANE-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                rd_out_q, rd_out_d;
    logic                rd_own_s_q, rd_own_s_d;
    logic [31:0]         stride;

`ifdef VLSU_STRIDE_EN
    logic [31:0]         stride_q, stride_d;
    assign stride = stride_q;
`else
    assign stride = STRIDE_FIXED;
`endif

    logic elem_mis, req_s, req_v, grant_s, grant_v;
    logic accept, v_acc, rd_ret, vec_ret, last_lane;

    // addr_q always holds the current element address, so alignment is per element.
    assign elem_mis  = word_misaligned(addr_q);
    assign req_s     = s_req_valid & ~rd_out_q;
    assign req_v     = (state_q == ST_REQ) & ~elem_mis & ~rd_out_q;
    assign last_lane = (k_q == K_LAST);

    mem_arb2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req_s_i   (req_s),
        .req_v_i   (req_v),
        .accept_i  (accept),
        .grant_s_o (grant_s),
        .grant_v_o (grant_v)
    );

    assign mem_req_valid = req_s | req_v;
    assign accept        = mem_req_valid & mem_req_ready;
    assign s_req_ready   = mem_req_ready & grant_s;
    assign v_acc         = mem_req_ready & grant_v;
    assign mem_we        = grant_s ? s_we    : (op_q == OP_VSW);
    assign mem_addr      = grant_s ? s_addr  : addr_q;
    assign mem_wdata     = grant_s ? s_wdata : wdata_q[32*k_q +: 32];

    assign rd_ret   = mem_rvalid & rd_out_q;
    assign s_rvalid = rd_ret & rd_own_s_q;
    assign s_rdata  = mem_rdata;
    assign vec_ret  = rd_ret & ~rd_own_s_q;

    assign issue_ready = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = done & err_q;
    assign rdata       = rdata_q;

    always_comb begin
        rd_out_d   = rd_out_q;
        rd_own_s_d = rd_own_s_q;
        if (rd_ret) begin
            rd_out_d = 1'b0;
        end
        if (accept && !mem_we) begin
            rd_out_d   = 1'b1;
            rd_own_s_d = grant_s;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef VLSU_STRIDE_EN
        stride_d = stride_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    op_d    = issue_store;
                    addr_d  = issue_base + issue_imm;
                    wdata_d = issue_wdata;
                    k_d     = '0;
                    err_d   = 1'b0;
`ifdef VLSU_STRIDE_EN
                    stride_d = issue_stride;
`endif
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (elem_mis) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (v_acc) begin
                    if (op_q == OP_VLW) begin
                        state_d = ST_WAIT;
                    end else if (last_lane) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d    = k_q + 1'b1;
                        addr_d = addr_q + stride;
                    end
                end
            end
            ST_WAIT: begin
                if (vec_ret) begin
                    rdata_d[32*k_q +: 32] = mem_rdata;
                    if (last_lane) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        addr_d  = addr_q + stride;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            op_q       <= OP_VLW;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            rd_out_q   <= 1'b0;
            rd_own_s_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            rd_out_q   <= rd_out_d;
            rd_own_s_q <= rd_own_s_d;
        end
    end

`ifdef VLSU_STRIDE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stride_q <= STRIDE_FIXED;
        end else begin
            stride_q <= stride_d;
        end
    end
`endif

endmodule

// File: tb/tb_vlsu_seq.sv
// Bench for vlsu_seq: memory/scalar model driven from one sequence of directed
// and randomized steps; expectations come from address/data arithmetic.
module tb_vlsu_seq;

    localparam int NL = 4;

    logic              clk;
    logic              rstn;
    logic              issue_valid, issue_ready, issue_store;
    logic [31:0]       issue_base, issue_imm, issue_stride;
    logic [32*NL-1:0]  issue_wdata;
    logic              done, err;
    logic [32*NL-1:0]  rdata;
    logic              s_req_valid, s_req_ready, s_we, s_rvalid;
    logic [31:0]       s_addr, s_wdata, s_rdata;
    logic              mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;

    vlsu_seq #(.NLANE(NL)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_store   (issue_store),
        .issue_base    (issue_base),
        .issue_imm     (issue_imm),
`ifdef VLSU_STRIDE_EN
        .issue_stride  (issue_stride),
`endif
        .issue_wdata   (issue_wdata),
        .done          (done),
        .err           (err),
        .rdata         (rdata),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_we          (s_we),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_rvalid      (s_rvalid),
        .s_rdata       (s_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        own_s;
        bit        we;
        bit [31:0] addr;
        bit [31:0] data;
    } acc_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit [31:0]   mem [bit [31:0]];
    acc_t        log_q [$];
    bit          rsp_pend = 0;
    int          rsp_wait = 0;
    bit [31:0]   rsp_data = 0;
    bit          rsp_own_s = 0;
    bit          rv_own_s = 0;
    bit [31:0]   rv_data = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    bit          rdy_rand = 0;
    bit          s_active = 0;
    bit          s_wr_en = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          done_err = 0;
    bit          issue_acc = 0;
    int          issue_cyc = 0;
    logic [32*NL-1:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] memrd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic new_scalar();
        s_addr      = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        s_we        = s_wr_en & 1'($urandom_range(0, 1));
        s_wdata     = $urandom;
        s_req_valid = 1'b1;
    endtask

    // One clock: observe just before the rising edge, drive just after it.
    task automatic tick();
        bit   hs_s, hs_i;
        acc_t e;
        @(negedge clk);
        #4;
        cyc++;
        hs_s = s_req_valid && s_req_ready;
        hs_i = issue_valid && issue_ready;
        if (rsp_pend || mem_rvalid) chk("no_req_while_read_outstanding", mem_req_valid, 1'b0);
        if (mem_rvalid) begin
            chk("s_rvalid_route", s_rvalid, rv_own_s);
            if (rv_own_s) chk("s_rdata", s_rdata, rv_data);
        end else if (s_rvalid) begin
            chk("s_rvalid_spurious", s_rvalid, 1'b0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        if (mem_req_valid && mem_req_ready) begin
            e.own_s = hs_s;
            e.we    = mem_we;
            e.addr  = mem_addr;
            e.data  = mem_wdata;
            log_q.push_back(e);
            if (hs_s) chk("s_addr_pass", mem_addr, s_addr);
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
            end else begin
                rsp_pend  = 1'b1;
                rsp_wait  = $urandom_range(lat_hi, lat_lo);
                rsp_data  = memrd(mem_addr);
                rsp_own_s = hs_s;
            end
        end
        if (hs_i) begin
            issue_acc = 1'b1;
            issue_cyc = cyc;
        end
        @(posedge clk);
        #2;
        if (hs_i) issue_valid = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rsp_pend) begin
            if (rsp_wait == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_data;
                rv_own_s   = rsp_own_s;
                rv_data    = rsp_data;
                rsp_pend   = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
        mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hs_s) begin
            if (s_active) new_scalar();
            else s_req_valid = 1'b0;
        end
    endtask

    task automatic drain_scalar();
        s_active = 1'b0;
        for (int n = 0; n < 200 && (s_req_valid || rsp_pend || mem_rvalid); n++) tick();
        chk("scalar_drain", s_req_valid | rsp_pend, 1'b0);
    endtask

    task automatic run_vec(input string tag, input bit st, input logic [31:0] base,
                           input logic [31:0] imm, input logic [31:0] stride,
                           input logic [32*NL-1:0] wd, input bit start_scalar);
        logic [31:0] ea, a;
        logic [31:0] exp_addr [NL];
        logic [31:0] exp_ld [NL];
        int          m, start, d0, nv;
        bit          exp_err;
        ea = base + imm;
        m  = NL;
        for (int i = 0; i < NL; i++) begin
            a           = ea + stride * 32'(i);
            exp_addr[i] = a;
            exp_ld[i]   = memrd(a);
            if (m == NL && a[1:0] != 2'b00) m = i;
        end
        exp_err = (m != NL);
        start   = log_q.size();
        d0      = done_cnt;
        issue_acc    = 1'b0;
        issue_store  = st;
        issue_base   = base;
        issue_imm    = imm;
        issue_stride = stride;
        issue_wdata  = wd;
        issue_valid  = 1'b1;
        for (int n = 0; n < 50 && !issue_acc; n++) tick();
        chk({tag, "_issue_accept"}, issue_acc, 1'b1);
        if (start_scalar) begin
            s_active = 1'b1;
            new_scalar();
        end
        for (int n = 0; n < 500 && done_cnt == d0; n++) tick();
        chk({tag, "_done_seen"}, done_cnt != d0, 1'b1);
        nv = 0;
        for (int j = start; j < log_q.size(); j++) begin
            if (!log_q[j].own_s) begin
                if (nv < NL) begin
                    chk({tag, "_addr"}, log_q[j].addr, exp_addr[nv]);
                    chk({tag, "_we"}, log_q[j].we, st);
                    if (st) chk({tag, "_wdata"}, log_q[j].data, wd[nv*32 +: 32]);
                end
                nv++;
            end
        end
        chk({tag, "_elem_count"}, nv, m);
        if (!st) for (int i = 0; i < m; i++) exp_rdata[i*32 +: 32] = exp_ld[i];
        chk({tag, "_err"}, done_err, exp_err);
        if (exp_err && m == 0) chk({tag, "_err_latency"}, done_cyc - issue_cyc, 2);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        tick();
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        chk({tag, "_ready_after"}, issue_ready, 1'b1);
        repeat (2) tick();
        chk({tag, "_rdata_hold"}, rdata, exp_rdata);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        exp_rdata = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base, imm;
        logic [32*NL-1:0] wd;
        bit   st, mis;
        int   st0, d0;

        rstn = 1'b0;
        issue_valid = 0; issue_store = 0; issue_base = 0; issue_imm = 0;
        issue_stride = 32'd4; issue_wdata = '0;
        s_req_valid = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_s_rvalid", s_rvalid, 1'b0);
        chk("rst_rdata", rdata, '0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Directed: aligned load, store with negative immediate, misaligned load, wrap.
        for (int i = 0; i < NL; i++) mem[32'h110 + 4*i] = $urandom;
        run_vec("vlw_0x110", 1'b0, 32'h100, 32'h10, 32'd4, '0, 1'b0);
        wd = {32'd4, 32'd3, 32'd2, 32'd1};
        run_vec("vsw_0x1fc", 1'b1, 32'h200, 32'hFFFF_FFFC, 32'd4, wd, 1'b0);
        chk("vsw_mem_0x1fc", memrd(32'h1FC), 32'd1);
        chk("vsw_mem_0x208", memrd(32'h208), 32'd4);
        run_vec("vlw_misalign", 1'b0, 32'h100, 32'h2, 32'd4, '0, 1'b0);
        run_vec("vlw_wrap", 1'b0, 32'hFFFF_FFF8, 32'h0, 32'd4, '0, 1'b0);

        // Randomized ops with random ready/latency, no scalar traffic.
        rdy_rand = 1'b1; lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 12; i++) begin
            st   = 1'($urandom_range(0, 1));
            mis  = (i % 4 == 3);
            base = $urandom_range(32'h7FFF_0000, 32'h0000_1000);
            imm  = 32'($urandom_range(0, 4095)) - 32'd2048;
            imm[1:0] = (mis ? 2'd2 : 2'd0) - base[1:0];
            wd   = {$urandom, $urandom, $urandom, $urandom};
            run_vec("rand_op", st, base, imm, 32'd4, wd, 1'b0);
        end

        // Randomized ops with concurrent scalar reads/writes in a disjoint region.
        s_wr_en = 1'b1; s_active = 1'b1; new_scalar();
        for (int i = 0; i < 6; i++) begin
            st   = 1'($urandom_range(0, 1));
            base = $urandom_range(32'h7FFF_0000, 32'h0000_1000) & 32'hFFFF_FFFC;
            wd   = {$urandom, $urandom, $urandom, $urandom};
            run_vec("rand_mixed", st, base, 32'h0, 32'd4, wd, 1'b0);
        end
        drain_scalar();

        // Continuous scalar reads against a vector load: strict S,V alternation.
        rdy_rand = 1'b0; lat_lo = 0; lat_hi = 0; s_wr_en = 1'b0;
        do_reset();
        st0 = log_q.size();
        run_vec("arb_vlw", 1'b0, 32'h400, 32'h0, 32'd4, '0, 1'b1);
        drain_scalar();
        chk("arb_log_len", (log_q.size() - st0) >= 2*NL, 1'b1);
        if ((log_q.size() - st0) >= 2*NL)
            for (int i = 0; i < 2*NL; i++) chk("arb_alternate", log_q[st0+i].own_s, (i % 2) == 0);

        // Reset while a vector load waits on lane 1, then a late read response.
        lat_lo = 6; lat_hi = 6;
        st0 = log_q.size();
        issue_acc = 1'b0; issue_store = 1'b0; issue_base = 32'h300; issue_imm = 32'h0;
        issue_stride = 32'd4; issue_valid = 1'b1;
        for (int n = 0; n < 60 && (log_q.size() - st0) < 2; n++) tick();
        chk("rstw_two_reads", (log_q.size() - st0) >= 2, 1'b1);
        d0 = done_cnt;
        rstn = 1'b0;
        #1;
        chk("rstw_done_low", done, 1'b0);
        chk("rstw_issue_ready", issue_ready, 1'b1);
        chk("rstw_mem_req_valid", mem_req_valid, 1'b0);
        chk("rstw_rdata_clear", rdata, '0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (10) tick();
        chk("rstw_no_done", done_cnt - d0, 0);
        chk("rstw_issue_ready_after", issue_ready, 1'b1);
        chk("rstw_late_rvalid_ignored", rdata, '0);
        exp_rdata = '0;
        lat_lo = 0; lat_hi = 0;

`ifdef VLSU_STRIDE_EN
        run_vec("stride_0x20", 1'b0, 32'h0, 32'h0, 32'h20, '0, 1'b0);
        run_vec("stride_mis", 1'b1, 32'h40, 32'h0, 32'h6, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
